// File: rtl/cf_i2s_pkg.sv
// Shared types and default widths for the CF_I2S receive-drain controller.
package cf_i2s_pkg;

    localparam int CF_I2S_DW = 32;
    localparam int CF_I2S_AW = 4;
    localparam int CF_I2S_CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_WAIT  = 3'd2,
        ST_POP   = 3'd3,
        ST_HOLD  = 3'd4
    } drain_state_e;

endpackage

// File: rtl/cf_i2s_drain_ctrl.sv
// Drains the I2S receive FIFO in bursts onto a valid/ready stream with a last
// marker, and owns receiver enable, FIFO clear and the sticky overflow flag.
module cf_i2s_drain_ctrl
    import cf_i2s_pkg::*;
#(
    parameter int DW = CF_I2S_DW,
    parameter int AW = CF_I2S_AW,
    parameter int CW = CF_I2S_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] burst_len,
    input  logic [AW-1:0] fifo_level,
    input  logic          fifo_full,
    input  logic [DW-1:0] fifo_rdata,
    output logic          fifo_rd,
    output logic          fifo_clr,
    output logic          i2s_en,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          ovf_flag,
    input  logic          ovf_clr,
    output logic [CW-1:0] burst_cnt
);

    drain_state_e  state_q, state_d;
    logic          stop_pend_q, stop_pend_d;
    logic [AW-1:0] remaining_q, remaining_d;
    logic [DW-1:0] m_data_q, m_data_d;
    logic          m_valid_q, m_valid_d;
    logic          m_last_q, m_last_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] eff_len;

    // A zero burst length would never complete, so it behaves as one word.
    assign eff_len = (burst_len == '0) ? AW'(1) : burst_len;

    always_comb begin
        state_d     = state_q;
        stop_pend_d = stop_pend_q;
        remaining_d = remaining_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        burst_cnt_d = burst_cnt_q;
        fifo_rd     = 1'b0;
        fifo_clr    = 1'b0;
        i2s_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d     = ST_CLEAR;
                    burst_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                fifo_clr = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                i2s_en = 1'b1;
                if (stop || stop_pend_q) begin
                    state_d     = ST_IDLE;
                    stop_pend_d = 1'b0;
                end else if (fifo_full || (fifo_level >= eff_len)) begin
                    remaining_d = eff_len;
                    state_d     = ST_POP;
                end
            end
            ST_POP: begin
                i2s_en    = 1'b1;
                fifo_rd   = 1'b1;
                m_data_d  = fifo_rdata;
                m_last_d  = (remaining_q == AW'(1));
                m_valid_d = 1'b1;
                state_d   = ST_HOLD;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
            end
            ST_HOLD: begin
                i2s_en = 1'b1;
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                // A stop never truncates a burst; it is honoured back in WAIT.
                if (m_valid_q && m_ready) begin
                    m_valid_d   = 1'b0;
                    remaining_d = remaining_q - AW'(1);
                    if (m_last_q) begin
                        burst_cnt_d = burst_cnt_q + CW'(1);
                        state_d     = ST_WAIT;
                    end else begin
                        state_d = ST_POP;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting wins over a simultaneous clear so no overflow is ever missed.
        if (fifo_full && i2s_en) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            remaining_q <= '0;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            burst_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            remaining_q <= remaining_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            burst_cnt_q <= burst_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign busy      = (state_q != ST_IDLE);
    assign ovf_flag  = ovf_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: doc/cf_i2s_drain_ctrl.md
Name: cf_i2s_drain_ctrl

Overview:
Sequencing controller for the I2S receiver FIFO.
- Owns the receiver's enable and FIFO-clear inputs.
- Waits until the FIFO holds a full burst of samples, then pops them one at a time.
- Presents each sample on a valid/ready stream, with a last marker on the final word of the burst.
- Sits between the CF_I2S core and a DMA or bus-write engine, and tracks overflow of the receive FIFO.

Parameters:
DW, 32, sample/FIFO data width
AW, 4, FIFO level width (FIFO depth 2^AW)
CW, 16, completed-burst counter width

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin a capture session
stop  in  1  pulse: end session after the current burst
burst_len  in  AW  samples per burst; 0 is treated as 1
fifo_level  in  AW  I2S FIFO fill level
fifo_full  in  1  I2S FIFO full
fifo_rdata  in  DW  FIFO head word (first-word-fall-through)
fifo_rd  out  1  FIFO pop strobe
fifo_clr  out  1  FIFO clear strobe
i2s_en  out  1  I2S receiver enable
m_valid  out  1  stream data valid
m_data  out  DW  stream sample
m_last  out  1  final sample of burst
m_ready  in  1  stream sink ready
busy  out  1  high in any state other than IDLE
ovf_flag  out  1  sticky FIFO overflow indication
ovf_clr  in  1  clear ovf_flag
burst_cnt  out  CW  completed bursts since the last start

Behaviour:
Reset:
- All outputs are 0; FSM is in IDLE; internal stop_pend=0, remaining=0.
- Reset is asynchronous. Asserting it mid-burst drops m_valid immediately; the partial burst is lost.

FSM states: IDLE, CLEAR, WAIT, POP, HOLD.

IDLE:
- i2s_en=0.
- On start (and stop not high in the same cycle): go to CLEAR and zero burst_cnt.
- start and stop in the same cycle: stop wins, stay in IDLE.

CLEAR:
- fifo_clr=1 for exactly one cycle; i2s_en stays 0.
- Next state is WAIT.

WAIT:
- i2s_en=1.
- If stop or stop_pend: go to IDLE and clear stop_pend.
- Else if fifo_full or fifo_level >= eff_len (eff_len = burst_len, or 1 if burst_len is 0): latch remaining=eff_len and go to POP.
- burst_len is sampled only at this transition; changes mid-burst are ignored.

POP:
- fifo_rd=1 for one cycle.
- m_data <= fifo_rdata; m_last <= (remaining==1); m_valid <= 1.
- Next state is HOLD.

HOLD:
- m_valid, m_data and m_last are held stable until m_valid & m_ready.
- On handshake:
  - m_valid drops next cycle.
  - remaining decrements.
  - If the word was last: burst_cnt increments (wraps at 2^CW) and the FSM goes to WAIT.
  - Otherwise the FSM goes to POP.
- Throughput: at most one sample per 2 cycles.
- m_ready while m_valid=0 is ignored.

stop handling:
- stop in POP or HOLD sets stop_pend. The burst always completes, then WAIT exits to IDLE.
- stop in IDLE or CLEAR: no effect beyond the start-priority rule above.

start outside IDLE: ignored.

busy: high in every state except IDLE.

ovf_flag:
- Set in any cycle with fifo_full=1 and i2s_en=1.
- Cleared by ovf_clr; set has priority over a simultaneous clear.
- Not cleared by start.

Decomposition:
- Shared package cf_i2s_pkg:
  - FSM state enum (3-bit encoding, IDLE=0).
  - Default localparams DW=32, AW=4.
- No sub-module is warranted; the FSM, counters and overflow flag live in one module.

Test Plan:
1. Reset, then start with burst_len=4 → fifo_clr high exactly 1 cycle, i2s_en=1 from the next cycle.
   - Hold fifo_level=3: no fifo_rd.
   - Set fifo_level=4: 4 fifo_rd pulses, 4 words in FIFO order, m_last only on the 4th, burst_cnt=1.
2. Backpressure: m_ready=0 for 10 cycles in HOLD → m_valid stays high and m_data is unchanged for all 10 cycles; no extra fifo_rd until the handshake.
3. stop issued in the middle of word 2 of a 4-word burst → words 3–4 still delivered, then busy=0 and i2s_en=0 one cycle after WAIT; burst_cnt=1.
4. burst_len=0 with fifo_level=1 → single-word bursts, m_last=1 on every word.
5. fifo_full=1 with i2s_en=1 → ovf_flag=1 next cycle.
   - ovf_clr together with fifo_full → flag stays 1.
   - ovf_clr alone → flag 0.
6. Assert rst_n low during HOLD → m_valid, fifo_rd and i2s_en are 0 immediately; FSM is in IDLE after release; start and stop in the same cycle keeps the FSM in IDLE.
